// File: rtl/program_loader.sv
// Program loader: streams a binary image into program RAM from address 0 and locates
// the first code-section marker byte, then releases the CPU core.
module program_loader #(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned MEM_BYTES   = 8000000,
    parameter logic [7:0]  MARKER_BYTE = 8'd14
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [31:0]       code_start_addr,
    output logic [ADDR_W:0]   bytes_loaded,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_error,
    output logic [1:0]        error_code
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_BYTES - 1);

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrNoMarker = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   bytes_q;
    logic              marker_found_q;
    logic [31:0]       code_start_q;
    logic [1:0]        err_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic xfer;
    logic at_last;
    logic marker_hit;
    logic found_now;
    logic load_start;

    assign xfer       = in_valid & in_ready;
    assign at_last    = (ptr_q == LastAddr);
    // Only the first marker counts, and a marker in the final RAM byte has no code after it.
    assign marker_hit = xfer && (in_data == MARKER_BYTE) && !marker_found_q && (ptr_q < LastAddr);
    assign found_now  = marker_found_q | marker_hit;
    assign load_start = start && (state_q != StLoad);

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (xfer) begin
                    if (in_last) begin
                        state_d = found_now ? StDone : StError;
                    end else if (at_last) begin
                        state_d = StError;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        in_ready        = (state_q == StLoad);
        load_done       = (state_q == StDone);
        load_error      = (state_q == StError);
        cpu_run         = (state_q == StDone);
        error_code      = err_q;
        mem_we          = mem_we_q;
        mem_addr        = mem_addr_q;
        mem_wdata       = mem_wdata_q;
        code_start_addr = code_start_q;
        bytes_loaded    = bytes_q;
    end

    // Datapath: write pointer, RAM write port, marker tracking and error capture
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ptr_q          <= '0;
            bytes_q        <= '0;
            marker_found_q <= 1'b0;
            code_start_q   <= '0;
            err_q          <= ErrNone;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (load_start) begin
                ptr_q          <= '0;
                bytes_q        <= '0;
                marker_found_q <= 1'b0;
                code_start_q   <= '0;
                err_q          <= ErrNone;
            end else if (xfer) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= in_data;
                ptr_q       <= ptr_q + ADDR_W'(1);
                bytes_q     <= bytes_q + (ADDR_W + 1)'(1);
                if (marker_hit) begin
                    marker_found_q <= 1'b1;
                    code_start_q   <= 32'(ptr_q) + 32'd1;
                end
                if (in_last && !found_now) begin
                    err_q <= ErrNoMarker;
                end else if (!in_last && at_last) begin
                    err_q <= ErrOverflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard and a RAM model.
module tb_program_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_BYTES = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic [7:0]        in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_last  = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [31:0]       code_start_addr;
    logic [ADDR_W:0]   bytes_loaded;
    logic              cpu_run;
    logic              load_done;
    logic              load_error;
    logic [1:0]        error_code;

    program_loader #(
        .ADDR_W     (ADDR_W),
        .MEM_BYTES  (MEM_BYTES),
        .MARKER_BYTE(8'd14)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .start          (start),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .code_start_addr(code_start_addr),
        .bytes_loaded   (bytes_loaded),
        .cpu_run        (cpu_run),
        .load_done      (load_done),
        .load_error     (load_error),
        .error_code     (error_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t               exp_q[$];
    logic [7:0]        ram[int];
    int                total  = 0;
    int                passed = 0;
    logic [ADDR_W-1:0] addr_exp = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every RAM write must match the next accepted stream byte.
    always @(negedge CLOCK_50) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(mem_addr), 64'hffff_ffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
            ram[int'(mem_addr)] = mem_wdata;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        addr_exp = '0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLOCK_50); #1;
            end
        end
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge CLOCK_50);
        while (!in_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back('{addr: addr_exp, data: d});
            addr_exp++;
        end
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic done, input logic [1:0] ec,
                                input logic [31:0] csa, input int nbytes);
        @(negedge CLOCK_50);
        check({tag, "_done"},  64'(load_done), 64'(done));
        check({tag, "_run"},   64'(cpu_run), 64'(done));
        check({tag, "_err"},   64'(load_error), 64'(!done));
        check({tag, "_code"},  64'(error_code), 64'(ec));
        check({tag, "_csa"},   64'(code_start_addr), 64'(csa));
        check({tag, "_bytes"}, 64'(bytes_loaded), 64'(nbytes));
        check({tag, "_rdy"},   64'(in_ready), 64'd0);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge CLOCK_50);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},   64'(in_ready), 64'd0);
        check({tag, "_we"},    64'(mem_we), 64'd0);
        check({tag, "_run"},   64'(cpu_run), 64'd0);
        check({tag, "_csa"},   64'(code_start_addr), 64'd0);
        check({tag, "_done"},  64'(load_done), 64'd0);
        check({tag, "_err"},   64'(load_error), 64'd0);
        check({tag, "_code"},  64'(error_code), 64'd0);
        check({tag, "_bytes"}, 64'(bytes_loaded), 64'd0);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
    endtask

    logic [7:0] s1[6] = '{8'd5, 8'd9, 8'd14, 8'd1, 8'd2, 8'd3};
    logic [7:0] s2[4] = '{8'd14, 8'd7, 8'd14, 8'd4};
    logic [7:0] s6[8] = '{8'd40, 8'd41, 8'd14, 8'd42, 8'd43, 8'd14, 8'd44, 8'd45};

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_idle("reset");

        // 1: marker at addr 2
        @(posedge CLOCK_50); #1;
        pulse_start();
        for (int i = 0; i < 6; i++) send(s1[i], i == 5, 1'b0);
        @(negedge CLOCK_50);
        check("t1_done_with_we", 64'(load_done & mem_we), 64'd1);
        check_status("t1", 1'b1, 2'd0, 32'd3, 6);
        drain("t1");

        // 2: only the first marker counts
        pulse_start();
        for (int i = 0; i < 4; i++) send(s2[i], i == 3, 1'b0);
        check_status("t2", 1'b1, 2'd0, 32'd1, 4);
        drain("t2");
        check("t2_ram2", 64'(ram[2]), 64'd14);

        // 3: no marker
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'(i + 1), i == 2, 1'b0);
        check_status("t3", 1'b0, 2'd1, 32'd0, 3);
        drain("t3");

        // 4: overflow, ninth byte must never be accepted
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'(i + 20), 1'b0, 1'b0);
        check_status("t4", 1'b0, 2'd2, 32'd0, 8);
        begin
            bit seen_ready;
            seen_ready = 1'b0;
            in_data  = 8'd99;
            in_valid = 1'b1;
            repeat (5) begin
                @(negedge CLOCK_50);
                if (in_ready) seen_ready = 1'b1;
            end
            in_valid = 1'b0;
            check("t4_ninth_blocked", 64'(seen_ready), 64'd0);
        end
        drain("t4");

        // 5: marker only in the last RAM byte
        pulse_start();
        for (int i = 0; i < 8; i++) send((i == 7) ? 8'd14 : 8'(i + 60), i == 7, 1'b0);
        check_status("t5", 1'b0, 2'd1, 32'd0, 8);
        drain("t5");

        // 6: random gaps, full RAM with last on final byte
        pulse_start();
        for (int i = 0; i < 8; i++) send(s6[i], i == 7, 1'b1);
        check_status("t6", 1'b1, 2'd0, 32'd3, 8);
        drain("t6");
        for (int i = 0; i < 8; i++) check("t6_ram", 64'(ram[i]), 64'(s6[i]));

        // Reset mid-load with a byte offered, together with start
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'(i + 80), 1'b0, 1'b0);
        in_data  = 8'd90;
        in_valid = 1'b1;
        reset    = 1'b1;
        start    = 1'b1;
        @(posedge CLOCK_50); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        check_idle("midreset");
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        drain("midreset");
        check_idle("post_reset");

        // Reload from address 0
        pulse_start();
        for (int i = 0; i < 6; i++) send(s1[i], i == 5, 1'b1);
        check_status("reload", 1'b1, 2'd0, 32'd3, 6);
        drain("reload");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
